mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Y86-64 pipeline memory stage plus M/W pipeline register. Decodes the M-stage instruction into
//  read/write requests for the byte-addressed data ram, checks address bounds, and latches
//  status, valE, valM and destination registers into the W register for write-back.
//  Sits between the E/M pipeline register (upstream) and write-back/data ram (downstream).
// PARAMETERS
//  MEM_BYTES  1024  size of the data ram in bytes; a legal 8-byte access needs addr <= MEM_BYTES-8
// PORTS
//  clk_i          in   1   clock; all state updates on rising edge
//  rst_n_i        in   1   asynchronous active-low reset
//  M_stat_i       in   3   M-stage status (1 AOK, 2 HLT, 3 ADR, 4 INS)
//  M_icode_i      in   4   M-stage icode
//  M_valE_i       in   64  ALU result
//  M_valA_i       in   64  operand A (store data / pop address)
//  M_dstE_i       in   4   dest for valE (0xF = none)
//  M_dstM_i       in   4   dest for valM (0xF = none)
//  W_stall_i      in   1   hold W register
//  W_bubble_i     in   1   load NOP bubble into W register
//  ram_rdata_i    in   64  ram read data (combinational, little-endian)
//  ram_error_i    in   1   ram-reported access error
//  ram_r_en_o     out  1   ram read enable
//  ram_w_en_o     out  1   ram write enable (ram writes on rising edge)
//  ram_addr_o     out  64  ram byte address
//  ram_wdata_o    out  64  ram write data
//  m_stat_o       out  3   combinational M-stage status after memory check (forwarded to control)
//  W_stat_o, W_icode_o, W_valE_o, W_valM_o, W_dstE_o, W_dstM_o  out 3/4/64/64/4/4  W register
//  halted_o       out  1   sticky: W register has held a non-AOK status
// BEHAVIOUR
//  Decode (combinational):
//   - read for MRMOVQ(5), POPQ(B), RET(9); write for RMMOVQ(4), PUSHQ(A), CALL(8); else none.
//   - ram_addr_o = valA for POPQ/RET, valE for RMMOVQ/MRMOVQ/PUSHQ/CALL, else 0. ram_wdata_o = valA.
//  Error: adr_err = (read|write) & (addr > MEM_BYTES-8 | ram_error_i), unsigned 64-bit compare.
//   - m_stat_o = ADR(3) if adr_err else M_stat_i.
//  Write gating: ram_w_en_o = write & ~adr_err & M_stat_i==AOK & ~halted_o & ~W_stall_i.
//   No out-of-range or post-exception write ever reaches ram. ram_r_en_o = read & ~adr_err.
//  valM = ram_rdata_i when ram_r_en_o, else 0; captured into W in the same cycle (0 extra latency).
//  W register update on rising edge, priority: reset > halted > stall > bubble > load.
//   - reset (async, rst_n_i low): W_stat=AOK, W_icode=NOP(1), valE=valM=0, dstE=dstM=0xF, halted=0.
//   - halted_o=1: W register and halted_o hold until reset.
//   - stall: hold all W fields.  bubble: load reset values (NOP, AOK, 0xF dests).
//   - load: W_stat<=m_stat_o, W_icode<=M_icode_i, W_valE<=M_valE_i, W_valM<=valM, dests copied;
//     if m_stat_o==ADR, dstE and dstM load 0xF (no register write-back on faulting instruction).
//  halted_o sets on the edge a non-AOK W_stat is loaded; stall+bubble together: stall wins.
//  Reset mid-operation: outputs go to reset values immediately; no ram write issued while rst_n_i=0.
// TESTING
//  1 reset: pulse rst_n_i low mid-cycle -> W_icode=1, W_stat=1, dstE/dstM=F, halted_o=0 at once.
//  2 RMMOVQ valE=0x10 valA=0x1122334455667788 -> w_en=1 addr=0x10; next MRMOVQ valE=0x10
//    -> W_valM=0x1122334455667788 after one edge.
//  3 MRMOVQ valE=0x3F9 (MEM_BYTES=1024) -> m_stat_o=3, no read/write, W_stat=3, dests=F, halted_o=1.
//  4 PUSHQ valE=0x3F8 -> legal, writes bytes 0x3F8..0x3FF; CALL valE=0xFFFFFFFFFFFFFFF8 -> ADR.
//  5 POPQ valA=0x20 dstM=4 with W_stall_i=1 then 0 -> W held one cycle, then valM loaded, dstM=4.
//  6 after halt, RMMOVQ AOK valE=0x0 -> ram_w_en_o=0, W unchanged; stall+bubble same cycle -> hold.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-ram bus between the memory stage (master) and the byte-addressed data ram (slave).
interface mem_stage_if;
  logic        ram_r_en;
  logic        ram_w_en;
  logic [63:0] ram_addr;
  logic [63:0] ram_wdata;
  logic [63:0] ram_rdata;
  logic        ram_error;

  modport master (
    output ram_r_en, ram_w_en, ram_addr, ram_wdata,
    input  ram_rdata, ram_error
  );

  modport slave (
    input  ram_r_en, ram_w_en, ram_addr, ram_wdata,
    output ram_rdata, ram_error
  );
endinterface

// File: rtl/mem_stage.sv
// Y86-64 memory stage: decodes ram requests, bounds-checks the address and
// holds the M/W pipeline register with a sticky halt on any non-AOK status.
module mem_stage #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [2:0]       M_stat_i,
  input  logic [3:0]       M_icode_i,
  input  logic [63:0]      M_valE_i,
  input  logic [63:0]      M_valA_i,
  input  logic [3:0]       M_dstE_i,
  input  logic [3:0]       M_dstM_i,
  input  logic             W_stall_i,
  input  logic             W_bubble_i,
  mem_stage_if.master      ram,
  output logic [2:0]       m_stat_o,
  output logic [2:0]       W_stat_o,
  output logic [3:0]       W_icode_o,
  output logic [63:0]      W_valE_o,
  output logic [63:0]      W_valM_o,
  output logic [3:0]       W_dstE_o,
  output logic [3:0]       W_dstM_o,
  output logic             halted_o
);

  localparam logic [2:0]  S_AOK    = 3'd1;
  localparam logic [2:0]  S_ADR    = 3'd3;
  localparam logic [3:0]  I_NOP    = 4'h1;
  localparam logic [3:0]  I_RMMOVQ = 4'h4;
  localparam logic [3:0]  I_MRMOVQ = 4'h5;
  localparam logic [3:0]  I_CALL   = 4'h8;
  localparam logic [3:0]  I_RET    = 4'h9;
  localparam logic [3:0]  I_PUSHQ  = 4'hA;
  localparam logic [3:0]  I_POPQ   = 4'hB;
  localparam logic [3:0]  R_NONE   = 4'hF;
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic        adr_err;
  logic [63:0] val_m;

  always_comb begin
    mem_read  = (M_icode_i == I_MRMOVQ) || (M_icode_i == I_POPQ) || (M_icode_i == I_RET);
    mem_write = (M_icode_i == I_RMMOVQ) || (M_icode_i == I_PUSHQ) || (M_icode_i == I_CALL);
    mem_addr  = '0;
    if ((M_icode_i == I_POPQ) || (M_icode_i == I_RET))
      mem_addr = M_valA_i;
    else if (mem_read || mem_write)
      mem_addr = M_valE_i;
  end

  assign adr_err  = (mem_read || mem_write) && ((mem_addr > ADDR_MAX) || ram.ram_error);
  assign m_stat_o = adr_err ? S_ADR : M_stat_i;

  // Writes are the only irreversible side effect, so every blocking condition
  // (fault, prior exception, held W stage, reset) gates them here.
  assign ram.ram_w_en  = mem_write && !adr_err && (M_stat_i == S_AOK) && !halted_o
                         && !W_stall_i && rst_n_i;
  assign ram.ram_r_en  = mem_read && !adr_err;
  assign ram.ram_addr  = mem_addr;
  assign ram.ram_wdata = M_valA_i;
  assign val_m         = ram.ram_r_en ? ram.ram_rdata : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      W_stat_o  <= S_AOK;
      W_icode_o <= I_NOP;
      W_valE_o  <= '0;
      W_valM_o  <= '0;
      W_dstE_o  <= R_NONE;
      W_dstM_o  <= R_NONE;
      halted_o  <= 1'b0;
    end else if (!halted_o && !W_stall_i) begin
      if (W_bubble_i) begin
        W_stat_o  <= S_AOK;
        W_icode_o <= I_NOP;
        W_valE_o  <= '0;
        W_valM_o  <= '0;
        W_dstE_o  <= R_NONE;
        W_dstM_o  <= R_NONE;
      end else begin
        W_stat_o  <= m_stat_o;
        W_icode_o <= M_icode_i;
        W_valE_o  <= M_valE_i;
        W_valM_o  <= val_m;
        W_dstE_o  <= (m_stat_o == S_ADR) ? R_NONE : M_dstE_i;
        W_dstM_o  <= (m_stat_o == S_ADR) ? R_NONE : M_dstM_i;
        halted_o  <= (m_stat_o != S_AOK);
      end
    end
  end

endmodule
